// File: rtl/route_decoder.sv
// Recovers the 5-bit program behind a train route by watching station hops.
// Illegal hops are flagged, and the partial trip is discarded.
module route_decoder (
   input  logic       clk,
   input  logic       rst,
   input  logic       trip_start,
   input  logic [2:0] station,
   input  logic       station_vld,
   output logic [4:0] prog_seq_out,
   output logic       seq_valid,
   output logic       seq_err,
   output logic       busy,
   output logic [2:0] hop_cnt
);

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      DECODE = 1'b1
   } state_t;

   state_t     state_r;
   logic [2:0] prev_r;
   logic [3:0] shift_r;
   logic [2:0] succ0_s;
   logic [2:0] succ1_s;
   logic       match0_s;
   logic       match1_s;
   logic       legal_s;
   logic       bit_s;

   // Station graph: the station the controller moves to for a given program bit.
   function automatic logic [2:0] next_station(input logic [2:0] cur, input logic prog_bit);
      logic [2:0] nxt;
      case (cur)
         3'b000:  nxt = prog_bit ? 3'b001 : 3'b000;
         3'b001:  nxt = prog_bit ? 3'b100 : 3'b010;
         3'b010:  nxt = prog_bit ? 3'b100 : 3'b011;
         3'b011:  nxt = prog_bit ? 3'b100 : 3'b011;
         3'b100:  nxt = prog_bit ? 3'b101 : 3'b111;
         3'b101:  nxt = prog_bit ? 3'b110 : 3'b011;
         3'b110:  nxt = prog_bit ? 3'b110 : 3'b111;
         3'b111:  nxt = prog_bit ? 3'b101 : 3'b001;
         default: nxt = 3'b000;
      endcase
      return nxt;
   endfunction

   // Compare the incoming hop against both successors of the previous station.
   always_comb begin
      succ0_s  = next_station(prev_r, 1'b0);
      succ1_s  = next_station(prev_r, 1'b1);
      match0_s = (station == succ0_s);
      match1_s = (station == succ1_s);
      legal_s  = match0_s | match1_s;
      // Successors are always distinct, so a bit-1 match fully determines the bit.
      if (match1_s) begin
         bit_s = 1'b1;
      end else begin
         bit_s = 1'b0;
      end
   end

   // Trip FSM with registered status outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r      <= IDLE;
         prev_r       <= 3'b000;
         shift_r      <= 4'b0000;
         prog_seq_out <= 5'b00000;
         seq_valid    <= 1'b0;
         seq_err      <= 1'b0;
         busy         <= 1'b0;
         hop_cnt      <= 3'd0;
      end else begin
         seq_valid <= 1'b0;
         seq_err   <= 1'b0;
         case (state_r)
            IDLE: begin
               if (trip_start) begin
                  state_r <= DECODE;
                  busy    <= 1'b1;
                  prev_r  <= 3'b000;
                  shift_r <= 4'b0000;
                  hop_cnt <= 3'd0;
               end else begin
                  busy    <= 1'b0;
               end
            end
            DECODE: begin
               // A restart wins over any hop presented in the same cycle.
               if (trip_start) begin
                  busy    <= 1'b1;
                  prev_r  <= 3'b000;
                  shift_r <= 4'b0000;
                  hop_cnt <= 3'd0;
               end else if (station_vld) begin
                  if (!legal_s) begin
                     seq_err <= 1'b1;
                     state_r <= IDLE;
                     busy    <= 1'b0;
                     hop_cnt <= 3'd0;
                  end else if (hop_cnt == 3'd4) begin
                     prog_seq_out <= {shift_r, bit_s};
                     seq_valid    <= 1'b1;
                     state_r      <= IDLE;
                     busy         <= 1'b0;
                     hop_cnt      <= 3'd0;
                     prev_r       <= station;
                  end else begin
                     shift_r <= {shift_r[2:0], bit_s};
                     prev_r  <= station;
                     hop_cnt <= hop_cnt + 3'd1;
                  end
               end else begin
                  busy <= 1'b1;
               end
            end
            default: begin
               state_r <= IDLE;
               busy    <= 1'b0;
               hop_cnt <= 3'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_route_decoder.sv
// Bench for route_decoder: directed trips plus random hops against a
// queue-based route model.
module tb_route_decoder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       trip_start = 1'b0;
   logic       station_vld = 1'b0;
   logic [2:0] station = 3'b000;
   logic [4:0] prog_seq_out;
   logic       seq_valid;
   logic       seq_err;
   logic       busy;
   logic [2:0] hop_cnt;

   int n_checks = 0;
   int n_errors = 0;

   // succ_tbl[s][b]: station reached from s when the program bit is b
   int succ_tbl [8][2] = '{'{0,1}, '{2,4}, '{3,4}, '{3,4},
                           '{7,5}, '{3,6}, '{7,6}, '{1,5}};

   bit m_active = 1'b0;
   int m_prev   = 0;
   int m_bits [$];
   int m_prog   = 0;
   bit m_valid  = 1'b0;
   bit m_err    = 1'b0;
   int valid_cnt = 0;
   int err_cnt   = 0;

   route_decoder dut (
      .clk          (clk),
      .rst          (rst),
      .trip_start   (trip_start),
      .station      (station),
      .station_vld  (station_vld),
      .prog_seq_out (prog_seq_out),
      .seq_valid    (seq_valid),
      .seq_err      (seq_err),
      .busy         (busy),
      .hop_cnt      (hop_cnt)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_active = 1'b0;
      m_prev   = 0;
      m_bits.delete();
      m_prog   = 0;
      m_valid  = 1'b0;
      m_err    = 1'b0;
   endtask

   task automatic model_step(input bit ts, input bit vld, input int st);
      int found;
      int p;
      found   = -1;
      m_valid = 1'b0;
      m_err   = 1'b0;
      if (ts) begin
         m_active = 1'b1;
         m_prev   = 0;
         m_bits.delete();
      end else if (m_active && vld) begin
         for (int b = 0; b < 2; b++)
            if (succ_tbl[m_prev][b] == st) found = b;
         if (found < 0) begin
            m_err    = 1'b1;
            m_active = 1'b0;
            m_bits.delete();
         end else begin
            m_bits.push_back(found);
            m_prev = st;
            if (m_bits.size() == 5) begin
               p = 0;
               foreach (m_bits[i]) p = p * 2 + m_bits[i];
               m_prog   = p;
               m_valid  = 1'b1;
               m_active = 1'b0;
               m_bits.delete();
            end
         end
      end
   endtask

   task automatic check_outputs();
      check_val("prog",  prog_seq_out, m_prog);
      check_val("valid", seq_valid, m_valid);
      check_val("err",   seq_err, m_err);
      check_val("busy",  busy, m_active);
      check_val("hops",  hop_cnt, m_bits.size());
   endtask

   task automatic cycle(input bit ts, input bit vld, input logic [2:0] st);
      trip_start  = ts;
      station_vld = vld;
      station     = st;
      @(posedge clk);
      model_step(ts, vld, int'(st));
      #1;
      check_outputs();
      if (seq_valid === 1'b1) valid_cnt++;
      if (seq_err === 1'b1) err_cnt++;
      trip_start  = 1'b0;
      station_vld = 1'b0;
   endtask

   task automatic hop(input logic [2:0] st);
      cycle(1'b0, 1'b1, st);
   endtask

   task automatic start();
      cycle(1'b1, 1'b0, 3'b000);
   endtask

   task automatic idle();
      cycle(1'b0, 1'b0, 3'b000);
   endtask

   initial begin
      logic [2:0] st;
      bit ts;
      bit vld;

      #1 rst = 1'b0;
      #1;
      model_reset();
      check_outputs();
      repeat (2) @(negedge clk);
      rst = 1'b1;

      // basic decode 10001
      valid_cnt = 0; err_cnt = 0;
      start(); hop(3'd1); hop(3'd2); hop(3'd3); hop(3'd3); hop(3'd4);
      check_val("t1_prog", prog_seq_out, 32'h11);
      check_val("t1_vcnt", valid_cnt, 32'd1);
      check_val("t1_ecnt", err_cnt, 32'd0);

      // self-loops with gaps, then all-ones
      start();
      for (int i = 0; i < 5; i++) begin
         hop(3'd0); idle(); idle();
      end
      check_val("t2_zero", prog_seq_out, 32'h00);
      start(); hop(3'd1); hop(3'd4); hop(3'd5); hop(3'd6); hop(3'd6);
      check_val("t2_ones", prog_seq_out, 32'h1f);

      // illegal hop and ignored hop afterwards
      err_cnt = 0;
      start(); hop(3'd2);
      check_val("t3_ecnt", err_cnt, 32'd1);
      check_val("t3_busy", busy, 32'd0);
      check_val("t3_prog", prog_seq_out, 32'h1f);
      hop(3'd1);
      check_val("t3_ign_busy", busy, 32'd0);
      check_val("t3_ign_hops", hop_cnt, 32'd0);

      // restart mid-trip
      valid_cnt = 0; err_cnt = 0;
      start(); hop(3'd1); hop(3'd2);
      start(); hop(3'd0); hop(3'd1); hop(3'd2); hop(3'd4); hop(3'd7);
      check_val("t4_vcnt", valid_cnt, 32'd1);
      check_val("t4_prog", prog_seq_out, 32'h0a);
      check_val("t4_ecnt", err_cnt, 32'd0);

      // trip_start colliding with a hop
      valid_cnt = 0;
      cycle(1'b1, 1'b1, 3'd1);
      for (int i = 0; i < 4; i++) hop(3'd0);
      check_val("t5_hops", hop_cnt, 32'd4);
      check_val("t5_busy", busy, 32'd1);
      check_val("t5_vcnt", valid_cnt, 32'd0);
      hop(3'd0);
      check_val("t5_prog", prog_seq_out, 32'h00);
      check_val("t5_vcnt2", valid_cnt, 32'd1);

      // async reset mid-trip
      start(); hop(3'd1); hop(3'd4); hop(3'd5);
      start(); hop(3'd1); hop(3'd2); hop(3'd3);
      #2 rst = 1'b0;
      #1;
      model_reset();
      check_val("t6_prog", prog_seq_out, 32'h00);
      check_val("t6_busy", busy, 32'd0);
      check_val("t6_hops", hop_cnt, 32'd0);
      check_val("t6_valid", seq_valid, 32'd0);
      check_val("t6_err", seq_err, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      valid_cnt = 0;
      start(); hop(3'd1); hop(3'd2); hop(3'd3); hop(3'd3); hop(3'd4);
      check_val("t6_after", prog_seq_out, 32'h11);
      check_val("t6_vcnt", valid_cnt, 32'd1);

      // random traffic, mostly legal hops
      for (int n = 0; n < 4000; n++) begin
         ts  = ($urandom_range(0, 99) < 6);
         vld = ($urandom_range(0, 99) < 65);
         if ($urandom_range(0, 9) < 8)
            st = 3'(succ_tbl[m_prev][$urandom_range(0, 1)]);
         else
            st = 3'($urandom_range(0, 7));
         cycle(ts, vld, st);
      end

      idle(); idle();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/route_decoder.md
# route_decoder

Receive-side counterpart of the train controller. Observes the station sequence the controller's route FSM produces, one hop per `station_vld`, starting from downtown. Recovers the 5-bit program that produced the route and flags routes the station graph cannot generate. Sits on the monitoring side of the controller's `station` output, for program readback and self-check.

## Interface
Parameters: none. Station graph and program length (5) are fixed.

- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-low reset
- `trip_start`  in  1  one-cycle pulse: a new trip begins at downtown (3'b000)
- `station`  in  3  station entered on this hop (encoding below)
- `station_vld`  in  1  `station` holds a valid hop this cycle
- `prog_seq_out`  out  5  last successfully decoded program; bit 4 = first hop
- `seq_valid`  out  1  one-cycle pulse: `prog_seq_out` just updated
- `seq_err`  out  1  one-cycle pulse: illegal hop, trip discarded
- `busy`  out  1  trip decode in progress
- `hop_cnt`  out  3  hops accepted in the current trip, 0..4

## Operation
- Station encoding and next station on bit 0 / bit 1:
  - 000 downtown: 000 / 001
  - 001 airport: 010 / 100
  - 010 state fair: 011 / 100
  - 011 umstead: 011 / 100
  - 100 mordecai: 111 / 101
  - 101 citi museum: 011 / 110
  - 110 ncsu: 111 / 110
  - 111 state capital: 001 / 101
- Every station has distinct bit-0 and bit-1 successors, so each legal hop decodes to exactly one bit.
- FSM states:
  - IDLE: `busy`=0; `station_vld` ignored.
  - DECODE: `busy`=1.
- IDLE→DECODE on `trip_start`:
  - `prev` ← 000
  - `hop_cnt` ← 0
  - shift register ← 0
- In DECODE, each `station_vld` is compared against `prev`'s successors:
  - Matches the bit-0 successor → shift in 0.
  - Matches the bit-1 successor → shift in 1.
  - After shifting: `prev` ← `station`, `hop_cnt` increments.
  - Bits shift in MSB first: the first hop lands in bit 4.
- Fifth legal hop (`hop_cnt`==4):
  - `prog_seq_out` ← {shifted bits, new bit}
  - `seq_valid` pulses
  - → IDLE, `hop_cnt` ← 0
- Hop matching neither successor:
  - `seq_err` pulses; → IDLE
  - `hop_cnt` ← 0; `prog_seq_out` unchanged
- `trip_start` while in DECODE restarts the decode; the partial trip is discarded silently, with no `seq_err`.
- `trip_start` and `station_vld` in the same cycle: `trip_start` wins and the hop is dropped.
- `prog_seq_out` holds its value until the next successful decode.

## Timing
- All state and outputs update on the rising `clk` edge. `rst` low clears asynchronously, regardless of clock.
- Reset values:
  - state IDLE
  - `prog_seq_out`=0, `seq_valid`=0, `seq_err`=0, `busy`=0, `hop_cnt`=0
  - `prev`=000, shift register=0
- Latency:
  - `seq_valid` and the new `prog_seq_out` are visible the cycle after the edge that samples the 5th hop.
  - `seq_err` is visible the cycle after the edge that samples the illegal hop.
- `busy` rises the cycle after `trip_start` is sampled. It falls in the same cycle that `seq_valid` or `seq_err` is high.
- Hops may be back-to-back (`station_vld` every cycle) or spaced by any idle gap. Gaps do not affect decode.
- No backpressure: a new trip may start on the cycle immediately after `seq_valid`.
- `rst` asserted mid-trip aborts the decode. No pulse is emitted and `prog_seq_out` returns to 0.

## Test plan
- Decode 10001: `trip_start`, then hops 001, 010, 011, 011, 100 back-to-back → `seq_valid` once, `prog_seq_out`=5'b10001, `seq_err`=0.
- Self-loops and gaps: hops 000 ×5 with 2 idle cycles between each → 5'b00000. Then hops 001, 100, 101, 110, 110 → 5'b11111.
- Illegal hop: `trip_start`, hop 010 from downtown → `seq_err` pulse, `busy`=0, `prog_seq_out` keeps its previous value. A following `station_vld` with no `trip_start` is ignored.
- Restart: `trip_start`, hops 001, 010, then `trip_start`, then hops 000, 001, 010, 100, 111 → only one `seq_valid`, `prog_seq_out`=5'b01010, no `seq_err`.
- Collision: `trip_start` and `station_vld`(001) in the same cycle, then 4 hops 000 → no `seq_valid` (only 4 hops counted; `hop_cnt`=4, `busy`=1). A 5th hop 000 → 5'b00000.
- Reset: `rst` low asynchronously after 3 hops → all outputs 0 immediately, before the next edge. After release, a full 10001 trip decodes correctly.
